ram_1kx8: RTL and testbench

- Single-port synchronous RAM: 1024 words x 8 bits, one shared address bus, one write-enable (wr).
- Used as a general scratch/storage memory in the datapath.
- Read data is registered. Reset does not erase the array; instead it invalidates every word, so unwritten or invalidated locations read as zero.

---
 rtl/ram_1kx8_if.sv | 25 ++
 rtl/ram_1kx8.sv | 48 ++++
 tb/tb_ram_1kx8.sv | 108 ++++++++++
 3 files changed

// File: rtl/ram_1kx8_if.sv
// Bus bundle for the 1Kx8 single-port RAM: write strobe, shared address,
// write data and registered read data.
interface ram_1kx8_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) ();
    logic              wr;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output wr,
        output add,
        output data_in,
        input  data_out
    );

    modport slave (
        input  wr,
        input  add,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/ram_1kx8.sv
// Single-port synchronous RAM with registered, write-first read data.
// Reset invalidates every word instead of clearing the array.
module ram_1kx8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input logic         clk,
    input logic         rst_n,
    ram_1kx8_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [DATA_W-1:0] rd_word;

    // Array has no reset; rst_n gates writes so reset-time writes are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && bus.wr) begin
            mem[bus.add] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (bus.wr) begin
            vld[bus.add] <= 1'b1;
        end
    end

    always_comb begin
        rd_word = '0;
        if (vld[bus.add]) begin
            rd_word = mem[bus.add];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out <= '0;
        end else if (bus.wr) begin
            bus.data_out <= bus.data_in;
        end else begin
            bus.data_out <= rd_word;
        end
    end
endmodule

// File: tb/tb_ram_1kx8.sv
// Directed self-checking bench for ram_1kx8: reset, write/read, write-first,
// boundaries, asynchronous mid-run reset and read latency.
module tb_ram_1kx8;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ram_1kx8_if #(.DATA_W(8), .ADDR_W(10)) bus ();

    ram_1kx8 #(.DATA_W(8), .ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one bus cycle, then land 1ns after the rising edge.
    task automatic cycle(input logic w, input logic [9:0] a, input logic [7:0] d);
        bus.wr      = w;
        bus.add     = a;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n       = 1'b0;
        bus.wr      = 1'b0;
        bus.add     = '0;
        bus.data_in = '0;

        // Reset with clock running
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", bus.data_out, 8'h00);
        #3 rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b0, 10'h000, 8'h00);
        check("unwritten_0", bus.data_out, 8'h00);

        // Write then read
        cycle(1'b1, 10'h31D, 8'h33); check("wr_31D", bus.data_out, 8'h33);
        cycle(1'b1, 10'h3FD, 8'h3F); check("wr_3FD", bus.data_out, 8'h3F);
        cycle(1'b1, 10'h39D, 8'h03); check("wr_39D", bus.data_out, 8'h03);
        cycle(1'b0, 10'h3FD, 8'h00); check("rd_3FD_a", bus.data_out, 8'h3F);
        cycle(1'b0, 10'h3FD, 8'h00); check("rd_3FD_b", bus.data_out, 8'h3F);
        cycle(1'b0, 10'h31D, 8'h00); check("rd_31D", bus.data_out, 8'h33);
        cycle(1'b0, 10'h39D, 8'h00); check("rd_39D", bus.data_out, 8'h03);

        // Read-after-write, last write wins
        cycle(1'b1, 10'h000, 8'hA5); check("wr_000_A5", bus.data_out, 8'hA5);
        cycle(1'b0, 10'h000, 8'h00); check("raw_000_A5", bus.data_out, 8'hA5);
        cycle(1'b1, 10'h000, 8'h5A); check("wr_000_5A", bus.data_out, 8'h5A);
        cycle(1'b0, 10'h000, 8'h00); check("raw_000_5A", bus.data_out, 8'h5A);

        // Boundaries
        cycle(1'b1, 10'h3FF, 8'hFF); check("wr_3FF", bus.data_out, 8'hFF);
        cycle(1'b1, 10'h000, 8'h01); check("wr_000_01", bus.data_out, 8'h01);
        cycle(1'b0, 10'h3FF, 8'h00); check("rd_3FF", bus.data_out, 8'hFF);
        cycle(1'b0, 10'h000, 8'h00); check("rd_000", bus.data_out, 8'h01);
        cycle(1'b0, 10'h3FE, 8'h00); check("rd_3FE", bus.data_out, 8'h00);

        // Latency: address change without an edge leaves data_out alone
        bus.add = 10'h3FF;
        #2;
        check("lat_hold", bus.data_out, 8'h00);
        @(posedge clk);
        #1;
        check("lat_update", bus.data_out, 8'hFF);

        // Asynchronous reset between edges, write attempted during reset
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", bus.data_out, 8'h00);
        cycle(1'b1, 10'h3FD, 8'h99);
        check("wr_in_rst", bus.data_out, 8'h00);
        bus.wr = 1'b0;
        #2 rst_n = 1'b1;
        cycle(1'b0, 10'h3FD, 8'h00); check("inval_3FD", bus.data_out, 8'h00);
        cycle(1'b0, 10'h31D, 8'h00); check("inval_31D", bus.data_out, 8'h00);
        cycle(1'b0, 10'h3FF, 8'h00); check("inval_3FF", bus.data_out, 8'h00);
        cycle(1'b1, 10'h3FD, 8'h77); check("rewr_3FD", bus.data_out, 8'h77);
        cycle(1'b0, 10'h3FD, 8'h00); check("rerd_3FD", bus.data_out, 8'h77);
        cycle(1'b0, 10'h39D, 8'h00); check("inval_39D", bus.data_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
